// File: rtl/decode_stage.sv
// Decode stage: splits the instruction word, reads operands with writeback bypass,
// extends imm16, and inserts a one-cycle bubble on a load-use hazard.
module decode_stage #(
  parameter int          HAZARD_EN = 1,
  parameter logic [5:0]  LOAD_OP   = 6'b100011,
  parameter logic [63:0] ZEXT_OPS  = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        flush,
  input  logic        valid_in,
  input  logic [31:0] pc,
  input  logic [31:0] command,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        wb_en,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_data,
  output logic        stall,
  output logic        d_valid,
  output logic [31:0] d_pc,
  output logic [5:0]  d_op,
  output logic [4:0]  d_rd,
  output logic [31:0] d_rs_val,
  output logic [31:0] d_rt_val,
  output logic [31:0] d_imm
);

  typedef struct packed {
    logic [31:0] pc;
    logic [5:0]  op;
    logic [4:0]  rd;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm;
  } dec_t;

  dec_t        dec_d, dec_q, dec_new;
  logic        vld_d, vld_q;
  logic [5:0]  op;
  logic [4:0]  rd;
  logic [15:0] imm16;
  logic        load_hit;

  // r0 reads as zero even if the writeback port targets it
  function automatic logic [31:0] operand(input logic [4:0] a, input logic [31:0] rf,
                                          input logic we, input logic [4:0] wr,
                                          input logic [31:0] wd);
    if (a == 5'd0)            operand = 32'h0;
    else if (we && (wr == a)) operand = wd;
    else                      operand = rf;
  endfunction

  assign op      = command[31:26];
  assign rd      = command[25:21];
  assign rs_addr = command[20:16];
  assign rt_addr = command[15:11];
  assign imm16   = command[15:0];

  always_comb begin
    dec_new        = '0;
    dec_new.pc     = pc;
    dec_new.op     = op;
    dec_new.rd     = rd;
    dec_new.rs_val = operand(rs_addr, rs_data, wb_en, wb_reg, wb_data);
    dec_new.rt_val = operand(rt_addr, rt_data, wb_en, wb_reg, wb_data);
    dec_new.imm    = ZEXT_OPS[op] ? {16'h0, imm16} : {{16{imm16[15]}}, imm16};
  end

  always_comb begin
    load_hit = (HAZARD_EN != 0) && vld_q && valid_in && (dec_q.op == LOAD_OP) &&
               (dec_q.rd != 5'd0) && ((dec_q.rd == rs_addr) || (dec_q.rd == rt_addr));
    stall    = load_hit && !flush;
  end

  // the bubble inserted on stall clears vld_q, so the hazard cannot repeat
  always_comb begin
    vld_d = vld_q;
    dec_d = dec_q;
    if (enable) begin
      if (flush || stall || !valid_in) begin
        vld_d = 1'b0;
        dec_d = '0;
      end else begin
        vld_d = 1'b1;
        dec_d = dec_new;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= 1'b0;
      dec_q <= '0;
    end else begin
      vld_q <= vld_d;
      dec_q <= dec_d;
    end
  end

  assign d_valid  = vld_q;
  assign d_pc     = dec_q.pc;
  assign d_op     = dec_q.op;
  assign d_rd     = dec_q.rd;
  assign d_rs_val = dec_q.rs_val;
  assign d_rt_val = dec_q.rt_val;
  assign d_imm    = dec_q.imm;

endmodule

// File: tb/tb_decode_stage.sv
// Vector table + scoreboard bench for decode_stage, with hand sequences for
// freeze, reset-mid-cycle and post-reset capture.
module tb_decode_stage;

  logic        clk, rst, enable, flush, valid_in;
  logic [31:0] pc, command, rs_data, rt_data, wb_data;
  logic [4:0]  rs_addr, rt_addr, wb_reg;
  logic        wb_en, stall, d_valid;
  logic [31:0] d_pc, d_rs_val, d_rt_val, d_imm;
  logic [5:0]  d_op;
  logic [4:0]  d_rd;

  decode_stage #(.HAZARD_EN(1), .LOAD_OP(6'b100011), .ZEXT_OPS(64'h1000)) dut (
    .clk(clk), .rst(rst), .enable(enable), .flush(flush), .valid_in(valid_in),
    .pc(pc), .command(command), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data), .wb_en(wb_en), .wb_reg(wb_reg),
    .wb_data(wb_data), .stall(stall), .d_valid(d_valid), .d_pc(d_pc),
    .d_op(d_op), .d_rd(d_rd), .d_rs_val(d_rs_val), .d_rt_val(d_rt_val), .d_imm(d_imm)
  );

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic [5:0]  op;
    logic [4:0]  rd;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] imm;
  } out_t;

  typedef struct {
    logic        flush;
    logic        valid_in;
    logic [31:0] pc;
    logic [31:0] cmd;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        wb_en;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        exp_stall;
    out_t        exp;
  } vec_t;

  out_t cur;
  assign cur = {d_valid, d_pc, d_op, d_rd, d_rs_val, d_rt_val, d_imm};

  int   checks = 0;
  int   errors = 0;
  out_t sb[$];
  vec_t vt[$];
  out_t zero_o;
  out_t held;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic out_t o(input logic v, input logic [31:0] p, input logic [5:0] op,
                             input logic [4:0] rd, input logic [31:0] rs,
                             input logic [31:0] rt, input logic [31:0] imm);
    o = {v, p, op, rd, rs, rt, imm};
  endfunction

  function automatic vec_t mk(input logic fl, input logic vi, input logic [31:0] p,
                              input logic [31:0] c, input logic [31:0] rsd,
                              input logic [31:0] rtd, input logic we, input logic [4:0] wr,
                              input logic [31:0] wd, input logic es, input out_t e);
    vec_t r;
    r.flush = fl; r.valid_in = vi; r.pc = p; r.cmd = c; r.rs_data = rsd;
    r.rt_data = rtd; r.wb_en = we; r.wb_reg = wr; r.wb_data = wd;
    r.exp_stall = es; r.exp = e;
    return r;
  endfunction

  task automatic chk_out(input string name, input out_t e);
    checks++;
    if (cur !== e) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, cur, e);
    end
  endtask

  task automatic chk_bit(input string name, input logic a, input logic e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s act=%b exp=%b", name, a, e);
    end
  endtask

  task automatic drive(input vec_t v);
    flush = v.flush; valid_in = v.valid_in; pc = v.pc; command = v.cmd;
    rs_data = v.rs_data; rt_data = v.rt_data; wb_en = v.wb_en;
    wb_reg = v.wb_reg; wb_data = v.wb_data;
  endtask

  task automatic apply(input string name, input vec_t v);
    out_t e;
    logic [31:0] c;
    @(negedge clk);
    enable = 1'b1;
    drive(v);
    c = v.cmd;
    #1;
    chk_bit({name, "_stall"}, stall, v.exp_stall);
    checks++;
    if ({rs_addr, rt_addr} !== {c[20:16], c[15:11]}) begin
      errors++;
      $display("FAIL %s_addr act=%h exp=%h", name, {rs_addr, rt_addr}, {c[20:16], c[15:11]});
    end
    sb.push_back(v.exp);
    @(posedge clk);
    #1;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s_sb_empty act=0 exp=1", name);
    end else begin
      checks--;
      e = sb.pop_front();
      chk_out({name, "_out"}, e);
    end
  endtask

  initial begin
    zero_o = '0;
    rst = 1'b1; enable = 1'b0; flush = 1'b0; valid_in = 1'b0; pc = '0; command = '0;
    rs_data = '0; rt_data = '0; wb_en = 1'b0; wb_reg = '0; wb_data = '0;

    // basic decode, sign-extended imm
    vt.push_back(mk(0,1,32'h100,{6'h08,5'd3,5'd1,16'hFFFC},32'h5,32'h9,0,0,0,0,
                    o(1,32'h100,6'h08,5'd3,32'h5,32'h9,32'hFFFFFFFC)));
    // load rd=4, then a consumer of r4 stalls, then is captured
    vt.push_back(mk(0,1,32'h104,{6'h23,5'd4,5'd2,16'h0010},32'h11,32'h22,0,0,0,0,
                    o(1,32'h104,6'h23,5'd4,32'h11,32'h0,32'h10)));
    vt.push_back(mk(0,1,32'h108,{6'h00,5'd5,5'd4,16'h1800},32'h44,32'h33,0,0,0,1,zero_o));
    vt.push_back(mk(0,1,32'h108,{6'h00,5'd5,5'd4,16'h1800},32'h44,32'h33,0,0,0,0,
                    o(1,32'h108,6'h00,5'd5,32'h44,32'h33,32'h1800)));
    // load rd=4, then rt=4 hazard with flush: flush wins
    vt.push_back(mk(0,1,32'h10C,{6'h23,5'd4,5'd0,16'h8000},32'h55,32'h66,0,0,0,0,
                    o(1,32'h10C,6'h23,5'd4,32'h0,32'h66,32'hFFFF8000)));
    vt.push_back(mk(1,1,32'h110,{6'h00,5'd6,5'd1,16'h2000},32'h1,32'h2,0,0,0,0,zero_o));
    // load to r0 never stalls
    vt.push_back(mk(0,1,32'h114,{6'h23,5'd0,5'd1,16'h0000},32'h7,32'h8,0,0,0,0,
                    o(1,32'h114,6'h23,5'd0,32'h7,32'h0,32'h0)));
    vt.push_back(mk(0,1,32'h118,{6'h01,5'd2,5'd0,16'h0001},32'h3,32'h4,0,0,0,0,
                    o(1,32'h118,6'h01,5'd2,32'h0,32'h0,32'h1)));
    // writeback bypass on rs, r0 ignores bypass, bypass on rt
    vt.push_back(mk(0,1,32'h11C,{6'h02,5'd1,5'd7,16'h0800},32'h1,32'h3,1,5'd7,32'hAA,0,
                    o(1,32'h11C,6'h02,5'd1,32'hAA,32'h3,32'h800)));
    vt.push_back(mk(0,1,32'h120,{6'h02,5'd1,5'd0,16'h0000},32'h9,32'h9,1,5'd0,32'hBB,0,
                    o(1,32'h120,6'h02,5'd1,32'h0,32'h0,32'h0)));
    vt.push_back(mk(0,1,32'h124,{6'h02,5'd1,5'd3,16'h4800},32'h30,32'h1,1,5'd9,32'hCC,0,
                    o(1,32'h124,6'h02,5'd1,32'h30,32'hCC,32'h4800)));
    // load then invalid consumer: bubble, no stall
    vt.push_back(mk(0,1,32'h130,{6'h23,5'd5,5'd0,16'h0000},32'h1,32'h1,0,0,0,0,
                    o(1,32'h130,6'h23,5'd5,32'h0,32'h0,32'h0)));
    vt.push_back(mk(0,0,32'h134,{6'h00,5'd0,5'd5,16'h0000},32'h1,32'h1,0,0,0,0,zero_o));
    // opcode 0x0C zero-extends
    vt.push_back(mk(0,1,32'h138,{6'h0C,5'd1,5'd2,16'hF000},32'h2,32'h4,0,0,0,0,
                    o(1,32'h138,6'h0C,5'd1,32'h2,32'h4,32'h0000F000)));

    #12;
    chk_out("reset_state", zero_o);
    chk_bit("reset_stall", stall, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vt.size(); i++) apply($sformatf("vec%0d", i), vt[i]);

    // freeze with a pending load: stall follows inputs, state holds
    held = o(1,32'h200,6'h23,5'd4,32'h0,32'h0,32'h0);
    apply("frz_load", mk(0,1,32'h200,{6'h23,5'd4,5'd0,16'h0000},32'h0,32'h0,0,0,0,0,held));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      enable = 1'b0; flush = 1'b0; valid_in = 1'b1; pc = 32'h204 + 32'(k * 4);
      case (k)
        0:       command = {6'h00,5'd1,5'd4,16'h0000};
        1:       command = {6'h00,5'd2,5'd0,16'h2000};
        default: command = {6'h00,5'd3,5'd9,16'h0000};
      endcase
      #1;
      chk_bit($sformatf("frz_stall%0d", k), stall, (k < 2) ? 1'b1 : 1'b0);
      @(posedge clk);
      #1;
      chk_out($sformatf("frz_hold%0d", k), held);
    end

    // async reset pulse between edges while a hazard is presented
    #1;
    rst = 1'b1; enable = 1'b1; command = {6'h00,5'd1,5'd4,16'h0000};
    #1;
    chk_out("rst_mid_out", zero_o);
    chk_bit("rst_mid_stall", stall, 1'b0);
    #1;
    rst = 1'b0;
    apply("post_rst", mk(0,1,32'h300,{6'h00,5'd7,5'd4,16'h0000},32'h77,32'h0,0,0,0,0,
                         o(1,32'h300,6'h00,5'd7,32'h77,32'h0,32'h0)));

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain act=%0d exp=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
